// File: rtl/apb4_mst_bridge.sv
// APB4 master bridge: turns a valid/ready command into one APB4 transfer
// (SETUP then ACCESS) and returns the result on a valid/ready response port.
// A wait counter can abort an ACCESS phase that never sees pready_i.
module apb4_mst_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                    pclk,
  input  logic                    presetn,
  // Command port
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  // Response port
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  // APB4 master
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam int unsigned CntWidth  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          TimeoutEn = (TIMEOUT != 0);
  localparam logic [CntWidth-1:0] CntLast =
      TimeoutEn ? CntWidth'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                  state_q, state_d;
  logic                    req_ready_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [StrbWidth-1:0]    pstrb_q;
  logic [CntWidth-1:0]     cnt_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;
  logic                    rsp_timeout_q;
  logic                    accept;
  logic                    timeout_hit;

  assign accept      = (state_q == StIdle) && req_valid_i && req_ready_q;
  // pready_i on the threshold cycle completes normally, so it masks the abort
  assign timeout_hit = TimeoutEn && (state_q == StAccess) && (cnt_q == CntLast) && !pready_i;

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (pready_i || timeout_hit) state_d = StResp;
      StResp:   if (rsp_ready_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // APB strobes and response valid decoded from the current state only
  always_comb begin
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      StSetup:  psel_o = 1'b1;
      StAccess: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
      end
      StResp:   rsp_valid_o = 1'b1;
      default:  ;
    endcase
  end

  // Ready is registered so it reads 0 while in reset and rises on the first edge after
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      req_ready_q <= 1'b0;
    end else begin
      req_ready_q <= (state_d == StIdle);
    end
  end

  // Command latch; held through IDLE/RESP so the bus shows the last transfer
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
    end else if (accept) begin
      paddr_q  <= req_addr_i;
      pwrite_q <= req_write_i;
      pwdata_q <= req_wdata_i;
      pstrb_q  <= req_write_i ? req_strb_i : '0;
    end
  end

  // Wait counter: cleared entering SETUP, counts stalled ACCESS cycles, saturates
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if ((state_q == StAccess) && !pready_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Response capture at the end of ACCESS
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else if ((state_q == StAccess) && pready_i) begin
      rsp_rdata_q   <= pwrite_q ? '0 : prdata_i;
      rsp_err_q     <= pslverr_i;
      rsp_timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b1;
      rsp_timeout_q <= 1'b1;
    end
  end

  assign req_ready_o   = req_ready_q;
  assign paddr_o       = paddr_q;
  assign pprot_o       = 3'b000;
  assign pwrite_o      = pwrite_q;
  assign pwdata_o      = pwdata_q;
  assign pstrb_o       = pstrb_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb4_mst_bridge.sv
// Self-checking bench for apb4_mst_bridge (TIMEOUT=4). Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_apb4_mst_bridge;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        presetn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic [31:0] paddr, pwdata, prdata;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb4_mst_bridge #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .TIMEOUT    (TO)
  ) dut (
    .pclk          (clk),
    .presetn       (presetn),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_write_i   (req_write),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .req_strb_i    (req_strb),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_err_o     (rsp_err),
    .rsp_timeout_o (rsp_timeout),
    .paddr_o       (paddr),
    .pprot_o       (pprot),
    .psel_o        (psel),
    .penable_o     (penable),
    .pwrite_o      (pwrite),
    .pwdata_o      (pwdata),
    .pstrb_o       (pstrb),
    .pready_i      (pready),
    .prdata_i      (prdata),
    .pslverr_i     (pslverr)
  );

  // One full transfer with a model of the expected bus and response behaviour.
  // waits = ACCESS cycles with pready low before the slave answers.
  task automatic do_xfer(input bit write, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int waits, input bit slverr,
                         input logic [31:0] rdata, input int stall, input bit hold_valid,
                         input string tag);
    bit          to_exp, seen, stable_ok, stall_ok;
    int          acc_exp, k, acc_idx, psel_cnt, pen_cnt;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_strb;
    to_exp    = (waits >= int'(TO));
    acc_exp   = to_exp ? int'(TO) : waits + 1;
    exp_rdata = (to_exp || write) ? 32'h0 : rdata;
    exp_err   = to_exp || slverr;
    exp_strb  = write ? strb : 4'h0;

    @(negedge clk);
    req_valid = 1'b1;
    req_write = write;
    req_addr  = addr;
    req_wdata = wdata;
    req_strb  = strb;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept got req_ready=%b exp 1", tag, req_ready);
    end

    k = 0; acc_idx = 0; psel_cnt = 0; pen_cnt = 0; seen = 0; stable_ok = 1;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        if (hold_valid) begin
          req_addr  = $urandom;
          req_wdata = $urandom;
          req_strb  = 4'($urandom);
          req_write = ~write;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (psel) begin
        psel_cnt++;
        if ({paddr, pwrite, pwdata, pstrb, pprot} !== {addr, write, wdata, exp_strb, 3'b000})
          stable_ok = 0;
      end
      if (penable) begin
        pen_cnt++;
        pready  = (acc_idx == waits);
        pslverr = (acc_idx == waits) ? slverr : 1'($urandom);
        prdata  = (acc_idx == waits) ? rdata : $urandom;
        acc_idx++;
      end else begin
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
      end
      if (rsp_valid) seen = 1;
    end

    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s rsp_valid never seen within %0d cycles", tag, k);
    end
    checks++;
    if (k - 1 != acc_exp + 1) begin
      errors++;
      $display("FAIL %s latency got %0d exp %0d", tag, k - 1, acc_exp + 1);
    end
    checks++;
    if (psel_cnt != acc_exp + 1 || pen_cnt != acc_exp) begin
      errors++;
      $display("FAIL %s psel/penable cycles got %0d/%0d exp %0d/%0d", tag, psel_cnt, pen_cnt,
               acc_exp + 1, acc_exp);
    end
    checks++;
    if (!stable_ok) begin
      errors++;
      $display("FAIL %s bus fields unstable or wrong, last paddr=%h pwdata=%h pstrb=%h exp %h %h %h",
               tag, paddr, pwdata, pstrb, addr, wdata, exp_strb);
    end
    checks++;
    if ({rsp_rdata, rsp_err, rsp_timeout} !== {exp_rdata, exp_err, to_exp}) begin
      errors++;
      $display("FAIL %s response got rdata=%h err=%b to=%b exp rdata=%h err=%b to=%b", tag,
               rsp_rdata, rsp_err, rsp_timeout, exp_rdata, exp_err, to_exp);
    end

    stall_ok = 1;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout, req_ready, psel, penable} !==
          {1'b1, exp_rdata, exp_err, to_exp, 1'b0, 1'b0, 1'b0})
        stall_ok = 0;
    end
    if (stall > 0) begin
      checks++;
      if (!stall_ok) begin
        errors++;
        $display("FAIL %s stall hold got valid=%b ready=%b psel=%b exp 1 0 0", tag, rsp_valid,
                 req_ready, psel);
      end
    end

    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req_ready, psel, penable, paddr, pstrb} !==
        {1'b0, 1'b1, 1'b0, 1'b0, addr, exp_strb}) begin
      errors++;
      $display("FAIL %s idle after rsp got valid=%b ready=%b psel=%b paddr=%h exp 0 1 0 %h", tag,
               rsp_valid, req_ready, psel, paddr, addr);
    end
  endtask

  task automatic test_reset();
    presetn = 1'b0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_strb = 0;
    rsp_ready = 0; pready = 0; prdata = 0; pslverr = 0;
    #12;
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, paddr, pprot, psel, penable,
         pwrite, pwdata, pstrb} !== '0) begin
      errors++;
      $display("FAIL reset outputs not zero: ready=%b psel=%b paddr=%h", req_ready, psel, paddr);
    end
    @(negedge clk);
    presetn = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release req_ready got %b exp 1", req_ready);
    end
  endtask

  task automatic test_write();
    do_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0, 0, 1'b0, "write0");
  endtask

  task automatic test_read_wait();
    do_xfer(1'b0, 32'h04, $urandom, 4'hF, 3, 1'b0, 32'h12345678, 0, 1'b0, "read_wait3");
  endtask

  task automatic test_slverr();
    do_xfer(1'b1, 32'h20, 32'hCAFEF00D, 4'h3, 1, 1'b1, 32'h0, 0, 1'b0, "slverr");
  endtask

  task automatic test_timeout();
    do_xfer(1'b0, 32'h30, 32'h0, 4'hF, 10, 1'b0, 32'hAAAA5555, 0, 1'b0, "timeout");
    do_xfer(1'b0, 32'h34, 32'h0, 4'hF, int'(TO) - 1, 1'b0, 32'h5555AAAA, 0, 1'b0,
            "pready_at_limit");
  endtask

  task automatic test_stall();
    do_xfer(1'b0, 32'h40, 32'h0, 4'h0, 1, 1'b0, 32'h0BADF00D, 10, 1'b1, "rsp_stall");
  endtask

  task automatic test_back_to_back();
    int setups[$];
    int rsps;
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 32'h50; req_wdata = 32'h1; req_strb = 4'hF;
    rsp_ready = 1; pready = 1; pslverr = 0;
    rsps = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (psel && !penable) setups.push_back(i);
      if (rsp_valid) rsps++;
    end
    req_valid = 0;
    @(negedge clk);
    rsp_ready = 0; pready = 0;
    checks++;
    if (setups.size() != 3 || rsps != 3) begin
      errors++;
      $display("FAIL b2b setup/resp count got %0d/%0d exp 3/3", setups.size(), rsps);
    end
    for (int i = 1; i < setups.size(); i++) begin
      checks++;
      if (setups[i] - setups[i-1] != 4) begin
        errors++;
        $display("FAIL b2b spacing got %0d exp 4", setups[i] - setups[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    int k;
    bit bad;
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = 32'h60; req_strb = 4'hF; pready = 0;
    @(negedge clk);
    req_valid = 0;
    k = 0;
    while (!penable && k < 10) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    #2 presetn = 1'b0;
    #1;
    checks++;
    if ({psel, penable, req_ready, rsp_valid, paddr, rsp_err} !== '0) begin
      errors++;
      $display("FAIL mid_reset got psel=%b penable=%b ready=%b valid=%b exp all 0", psel,
               penable, req_ready, rsp_valid);
    end
    @(negedge clk);
    @(negedge clk);
    presetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid || psel) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL mid_reset dropped transfer produced activity got 1 exp 0");
    end
    do_xfer(1'b0, 32'h64, 32'h0, 4'hF, 0, 1'b0, 32'h87654321, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      do_xfer(1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 6)),
              1'($urandom), $urandom, int'($urandom_range(0, 3)), 1'($urandom), "random");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_stall();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
